// File: rtl/stream_checksum_if.sv
// Upstream byte handshake plus host control/readback for stream_checksum.
// The block itself uses the slave modport; the driving side uses master.
interface stream_checksum_if;
   logic [3:0]  ceiling_in;
   logic        clear_in;
   logic        snap_in;
   logic [7:0]  inData_in;
   logic        inValid_in;
   logic        inReady_out;
   logic [2:0]  sel_in;
   logic [7:0]  result_out;
   logic [15:0] sumLive_out;

   modport master (
      output ceiling_in, clear_in, snap_in, inData_in, inValid_in, sel_in,
      input  inReady_out, result_out, sumLive_out
   );

   modport slave (
      input  ceiling_in, clear_in, snap_in, inData_in, inValid_in, sel_in,
      output inReady_out, result_out, sumLive_out
   );
endinterface

// File: rtl/stream_checksum.sv
// Paced byte sink computing a Fletcher-16 checksum and a byte count,
// with a host-triggered snapshot that is read back one byte at a time.
module stream_checksum (
   input  logic             clk_in,
   input  logic             reset_in,
   stream_checksum_if.slave bus
);
   logic [3:0]  pace_reg,  pace_next;
   logic [15:0] count_reg, count_next;
   logic [7:0]  sumA_reg,  sumA_next;
   logic [7:0]  sumB_reg,  sumB_next;
   logic        overflow_reg, overflow_next;

   logic [15:0] snapCount_reg;
   logic [7:0]  snapSumA_reg;
   logic [7:0]  snapSumB_reg;
   logic        snapOverflow_reg;

   logic        inReady;
   logic        transfer;
   logic [7:0]  snapByte [8];

   // Operands never exceed 254 + 255, so a single conditional subtract
   // is enough to keep the result in 0..254.
   function automatic logic [7:0] modAdd255(input logic [7:0] x, input logic [7:0] y);
      logic [8:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= 9'd255) begin
         s = s - 9'd255;
      end
      return s[7:0];
   endfunction

   assign inReady         = reset_in && !bus.clear_in && (pace_reg == 4'd0);
   assign transfer        = bus.inValid_in && inReady;
   assign bus.inReady_out = inReady;
   assign bus.sumLive_out = {sumB_reg, sumA_reg};

   always_comb begin
      pace_next     = pace_reg;
      count_next    = count_reg;
      sumA_next     = sumA_reg;
      sumB_next     = sumB_reg;
      overflow_next = overflow_reg;
      if (bus.clear_in) begin
         pace_next     = 4'd0;
         count_next    = 16'd0;
         sumA_next     = 8'd0;
         sumB_next     = 8'd0;
         overflow_next = 1'b0;
      end else if (transfer) begin
         sumA_next  = modAdd255(sumA_reg, bus.inData_in);
         sumB_next  = modAdd255(sumB_reg, sumA_next);
         count_next = count_reg + 16'd1;
         if (count_reg == 16'hFFFF) begin
            overflow_next = 1'b1;
         end
         pace_next  = bus.ceiling_in;
      end else if (pace_reg != 4'd0) begin
         pace_next = pace_reg - 4'd1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         pace_reg         <= 4'd0;
         count_reg        <= 16'd0;
         sumA_reg         <= 8'd0;
         sumB_reg         <= 8'd0;
         overflow_reg     <= 1'b0;
         snapCount_reg    <= 16'd0;
         snapSumA_reg     <= 8'd0;
         snapSumB_reg     <= 8'd0;
         snapOverflow_reg <= 1'b0;
      end else begin
         pace_reg     <= pace_next;
         count_reg    <= count_next;
         sumA_reg     <= sumA_next;
         sumB_reg     <= sumB_next;
         overflow_reg <= overflow_next;
         // Snapshot takes the pre-edge live values, so a same-edge byte or clear is excluded.
         if (bus.snap_in) begin
            snapCount_reg    <= count_reg;
            snapSumA_reg     <= sumA_reg;
            snapSumB_reg     <= sumB_reg;
            snapOverflow_reg <= overflow_reg;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : gSnapByte
         if (gi == 0) begin : gCountLo
            assign snapByte[gi] = snapCount_reg[7:0];
         end else if (gi == 1) begin : gCountHi
            assign snapByte[gi] = snapCount_reg[15:8];
         end else if (gi == 2) begin : gSumA
            assign snapByte[gi] = snapSumA_reg;
         end else if (gi == 3) begin : gSumB
            assign snapByte[gi] = snapSumB_reg;
         end else if (gi == 4) begin : gOverflow
            assign snapByte[gi] = {7'd0, snapOverflow_reg};
         end else begin : gZero
            assign snapByte[gi] = 8'h00;
         end
      end
   endgenerate

   assign bus.result_out = snapByte[bus.sel_in];
endmodule

// File: doc/stream_checksum.md
STREAM_CHECKSUM -- requirements
Module: stream_checksum

Interface
REQ-001 clk_in  input  1  system clock (fx2Clk_in domain); all state changes on its rising edge.
REQ-002 reset_in  input  1  reset; one clock; reset is synchronous and active-low.
REQ-003 ceiling_in  input  4  drain pacing: at most one byte accepted per ceiling_in+1 cycles.
REQ-004 clear_in  input  1  synchronous clear of count, sums and overflow flag.
REQ-005 snap_in  input  1  capture live count/sums/flags into snapshot registers.
REQ-006 inData_in  input  8  byte from upstream FIFO consumer port.
REQ-007 inValid_in  input  1  upstream has a byte on inData_in.
REQ-008 inReady_out  output  1  block will take inData_in at next rising edge if inValid_in=1.
REQ-009 sel_in  input  3  snapshot byte select for readback.
REQ-010 result_out  output  8  selected snapshot byte (host channel readback).
REQ-011 sumLive_out  output  16  live {sumB,sumA} for display.

Function
REQ-012 Transfer occurs on an edge where inValid_in=1 and inReady_out=1; no other edge consumes a byte.
REQ-013 inReady_out SHALL be combinational: 1 iff reset_in=1, clear_in=0 and pace counter=0.
REQ-014 Pace counter: 4-bit; loads ceiling_in on a transfer, else decrements while nonzero; ceiling_in=0 gives one transfer per cycle.
REQ-015 Pace counter SHALL idle at 0 with inValid_in=0, so first byte after idle is accepted immediately.
REQ-016 Checksum is Fletcher-16: sumA' = (sumA + byte) mod 255; sumB' = (sumB + sumA') mod 255; both held in 0..254.
REQ-017 Modular reduction: 9-bit add, subtract 255 once if result >= 255; values 255 never stored.
REQ-018 sumA, sumB, count update on the transfer edge; sumLive_out reflects them the cycle after (latency 1).
REQ-019 Count: 16-bit byte counter, increments per transfer, wraps 0xFFFF -> 0x0000 and sets sticky overflow flag.
REQ-020 Overflow flag stays 1 until clear_in or reset.
REQ-021 clear_in=1: count, sumA, sumB, overflow, pace counter -> 0 at that edge; no transfer that cycle (clear wins over valid).
REQ-022 snap_in=1: snapshot regs load the pre-edge live values; a transfer on the same edge is excluded from the snapshot but applied to live state.
REQ-023 snap_in and clear_in together: snapshot gets pre-clear values; live state cleared.
REQ-024 result_out by sel_in: 0 count[7:0], 1 count[15:8], 2 sumA, 3 sumB, 4 {7'b0, overflow}, 5-7 8'h00; combinational from snapshot regs.
REQ-025 Changing ceiling_in mid-count affects only the next counter load.

Reset
REQ-026 reset_in=0 at an edge: count, sumA, sumB, overflow, pace counter, all snapshot regs -> 0.
REQ-027 While reset_in=0, inReady_out=0; no byte consumed during reset.
REQ-028 First edge with reset_in=1, clear_in=0, inValid_in=1 SHALL transfer a byte.
REQ-029 Reset overrides clear_in and snap_in.

Verification
REQ-030 Reset, ceiling_in=0, stream "abcde" (61..65) back-to-back, snap -> sel 3/2 read 8'hC8/8'hF0, sel 0 read 8'h05.
REQ-031 Append "f" (66), snap -> sumB/sumA 8'h20/8'h57, count 6; sumLive_out 16'h2057 one cycle after transfer.
REQ-032 ceiling_in=3, inValid_in held 1 for 16 cycles -> inReady_out high on cycles 0,4,8,12 only; exactly 4 transfers.
REQ-033 Push 65536 bytes of 8'hFF -> count 16'h0000, overflow 1, sumA 0, sumB 0.
REQ-034 clear_in and inValid_in=1 same cycle with snap_in=1 -> byte not consumed, snapshot holds pre-clear values, live state 0.
REQ-035 Assert reset_in=0 mid-stream (ceiling_in=2, counter nonzero) -> all outputs 0 next cycle; first byte after release accepted immediately.
